// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding, digit-count
// and counter-width helpers, signed saturation limits as functions of width.
// No ports (package).
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Saturation helpers return a MAX_WIDTH vector; callers keep the low WIDTH bits.
  localparam int MAX_WIDTH = 64;

  function automatic int ndig_f(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width: max(1, clog2(ndig)).
  function automatic int cnt_w_f(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  // Most positive signed value of a width-bit word.
  function automatic logic [MAX_WIDTH-1:0] smax_f(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  // Most negative signed value of a width-bit word.
  function automatic logic [MAX_WIDTH-1:0] smin_f(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fsub_digit.sv
// Combinational ripple of DIGIT full-subtractor cells: d = a - b - bin over one digit.
// Ports: a_i/b_i digit operands, bin_i borrow into the LSB, d_o digit difference,
//        bout_o borrow out of the digit MSB. Zero latency, no handshake.
module serial_subtractor_fsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] d_o,
  output logic             bout_o
);

  always_comb begin : p_ripple
    logic c;
    c   = bin_i;
    d_o = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d_o[i] = a_i[i] ^ b_i[i] ^ c;
      // Borrow when b wins outright, or when the bits tie and a borrow is pending.
      c = (~a_i[i] & b_i[i]) | (c & ~(a_i[i] ^ b_i[i]));
    end
    bout_o = c;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor diff = a - b - bin, DIGIT bits per clock.
// Latency: out_valid rises WIDTH/DIGIT cycles after the accepting edge; one op in flight.
// Backpressure: result held in DONE (in_ready low) until out_ready; in_valid ignored when busy.
// Ports: clk, rst (sync, active high); in_valid/in_ready + a, b, bin operands;
//        out_valid/out_ready + diff, bout (unsigned borrow), ovf (signed overflow).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = ndig_f(WIDTH, DIGIT);
  localparam int CW   = cnt_w_f(NDIG);
  localparam logic [CW-1:0]        CNT_LAST = CW'(NDIG - 1);
  localparam logic [MAX_WIDTH-1:0] SMAX_W   = smax_f(WIDTH);
  localparam logic [MAX_WIDTH-1:0] SMIN_W   = smin_f(WIDTH);
  localparam logic [WIDTH-1:0]     SMAX     = SMAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SMIN     = SMIN_W[WIDTH-1:0];

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $fatal(1, "serial_subtractor: WIDTH must be a multiple of DIGIT (1..WIDTH), WIDTH <= 64");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;   // difference digits produced so far
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] sl_a, sl_b, sl_d;
  logic             sl_bout;
  logic [WIDTH-1:0] full_d;
  logic             ovf_n;

  always_comb begin
    sl_a = a_q[cnt_q*DIGIT +: DIGIT];
    sl_b = b_q[cnt_q*DIGIT +: DIGIT];
  end

  serial_subtractor_fsub_digit #(.DIGIT(DIGIT)) u_fsub_digit (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .bin_i  (brw_q),
    .d_o    (sl_d),
    .bout_o (sl_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);

    // Difference including the digit being computed this cycle; complete on the last digit.
    full_d = part_q;
    full_d[cnt_q*DIGIT +: DIGIT] = sl_d;
    // Operands of opposite sign and a result sign that disagrees with a.
    ovf_n = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (full_d[WIDTH-1] ^ a_q[WIDTH-1]);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        part_d = full_d;
        brw_d  = sl_bout;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bout_d  = sl_bout;
          ovf_d   = ovf_n;
          if (SAT && ovf_n) begin
            diff_d = a_q[WIDTH-1] ? SMIN : SMAX;
          end else begin
            diff_d = full_d;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor across DIGIT = 4/16/1 and SAT = 0/1.
// All six configurations share inputs and are checked in lockstep.
module tb_serial_subtractor;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic        bin;

  logic        in_ready_w  [NI];
  logic        out_valid_w [NI];
  logic        bout_w      [NI];
  logic        ovf_w       [NI];
  logic [15:0] diff_w      [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instances 0..2: SAT=0 with DIGIT 4,16,1; instances 3..5: same with SAT=1.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DG = (g % 3 == 0) ? 4 : ((g % 3 == 1) ? 16 : 1);
    localparam bit SG = (g >= 3);
    serial_subtractor #(.WIDTH(16), .DIGIT(DG), .SAT(SG)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .diff      (diff_w[g]),
      .bout      (bout_w[g]),
      .ovf       (ovf_w[g])
    );
  end

  function automatic int lat_exp(input int idx);
    return (idx % 3 == 0) ? 4 : ((idx % 3 == 1) ? 1 : 16);
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Launch one operation at a negedge, wait for all results, check them; leaves DUTs in DONE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                        input logic [15:0] ew, input logic [15:0] es,
                        input logic eb, input logic eo);
    int lat [NI];
    bit all_done;
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1;
      chk("in_ready_idle", i, 32'(in_ready_w[i]), 32'd1);
    end
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        // Operands are free to change once accepted.
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      end
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] < 0 && out_valid_w[i] === 1'b1) lat[i] = cyc;
        if (lat[i] < 0) all_done = 1'b0;
      end
      if (all_done) break;
    end
    for (int i = 0; i < NI; i++) begin
      chk("latency", i, 32'(lat[i]), 32'(lat_exp(i)));
      chk("diff", i, 32'(diff_w[i]), (i >= 3) ? 32'(es) : 32'(ew));
      chk("bout", i, 32'(bout_w[i]), 32'(eb));
      chk("ovf", i, 32'(ovf_w[i]), 32'(eo));
    end
  endtask

  task automatic release_op();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("out_valid_drop", i, 32'(out_valid_w[i]), 32'd0);
      chk("in_ready_back", i, 32'(in_ready_w[i]), 32'd1);
    end
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb, ew, es;
    logic        rbin, eo;
    bit          seen_ov [NI];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_ready", i, 32'(in_ready_w[i]), 32'd1);
      chk("rst_out_valid", i, 32'(out_valid_w[i]), 32'd0);
      chk("rst_diff", i, 32'(diff_w[i]), 32'd0);
      chk("rst_bout", i, 32'(bout_w[i]), 32'd0);
      chk("rst_ovf", i, 32'(ovf_w[i]), 32'd0);
    end

    // Directed vectors: a, b, bin, wrapped diff, saturated diff, bout, ovf.
    run_op(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0); release_op();
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0); release_op();
    run_op(16'h0005, 16'h0003, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0); release_op();
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b1); release_op();
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b0, 1'b1); release_op();
    run_op(16'h0000, 16'h7FFF, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0); release_op();
    run_op(16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1); release_op();
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0); release_op();

    // Backpressure: result held for 10 cycles while in_valid toggles new operands.
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("hold_out_valid", i, 32'(out_valid_w[i]), 32'd1);
        chk("hold_in_ready", i, 32'(in_ready_w[i]), 32'd0);
        chk("hold_diff", i, 32'(diff_w[i]), (i >= 3) ? 32'h8000 : 32'h7FFF);
      end
    end
    release_op();

    // Reset during the second RUN cycle of the DIGIT=4 instances.
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0); release_op();
    a = 16'h1234; b = 16'h0235; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("midrst_out_valid", i, 32'(out_valid_w[i]), 32'd0);
      chk("midrst_diff", i, 32'(diff_w[i]), 32'd0);
      chk("midrst_bout", i, 32'(bout_w[i]), 32'd0);
      chk("midrst_ovf", i, 32'(ovf_w[i]), 32'd0);
      seen_ov[i] = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("midrst_in_ready", i, 32'(in_ready_w[i]), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) if (out_valid_w[i] !== 1'b0) seen_ov[i] = 1'b1;
    end
    for (int i = 0; i < NI; i++) chk("midrst_no_pulse", i, 32'(seen_ov[i]), 32'd0);

    // Random operands against an arithmetic reference.
    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (n == 0) begin ra = 16'h8000; rb = 16'h7FFF; rbin = 1'b1; end
      full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
      ew = full[15:0];
      eo = (ra[15] ^ rb[15]) & (ew[15] ^ ra[15]);
      es = eo ? (ra[15] ? 16'h8000 : 16'h7FFF) : ew;
      run_op(ra, rb, rbin, ew, es, full[16], eo);
      release_op();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
